// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational ALU: IDLE -> EXEC -> RESP, one operation in flight.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_srcA,
   input  logic [WIDTH-1:0] req0_srcB,
   input  logic [2:0]       req0_ctrl,
   input  logic [WIDTH-1:0] req1_srcA,
   input  logic [WIDTH-1:0] req1_srcB,
   input  logic [2:0]       req1_ctrl,
   output logic [WIDTH-1:0] alu_srcA,
   output logic [WIDTH-1:0] alu_srcB,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state;
   logic   gid;
   logic   accept;
   logic   sel1;
   logic [1:0] grant;

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic   last;
`endif

   // Grant policy: a lone requester always wins; ties resolved by policy.
   always_comb begin
      grant = 2'b00;
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
`else
      if (&req_valid) grant = last ? 2'b01 : 2'b10;
      else            grant = req_valid;
`endif
   end

   assign req_ready = (state == IDLE && !reset) ? grant : 2'b00;
   assign accept    = |req_ready;
   assign sel1      = req_ready[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         gid        <= 1'b0;
         alu_srcA   <= '0;
         alu_srcB   <= '0;
         alu_ctrl   <= 3'b000;
         rsp_valid  <= 2'b00;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         busy       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last       <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  gid      <= sel1;
                  alu_srcA <= sel1 ? req1_srcA : req0_srcA;
                  alu_srcB <= sel1 ? req1_srcB : req0_srcB;
                  alu_ctrl <= sel1 ? req1_ctrl : req0_ctrl;
                  state    <= EXEC;
                  busy     <= 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  last     <= sel1;
`endif
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_zero   <= alu_zero;
               rsp_valid  <= gid ? 2'b10 : 2'b01;
               state      <= RESP;
            end
            RESP: begin
               // Only the granted requester's ready bit releases the response.
               if (rsp_ready[gid]) begin
                  rsp_valid <= 2'b00;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 2'b00;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random traffic vs a transaction-level model.
module tb_alu_share_arbiter;

   localparam int unsigned W = 32;

   logic         clk;
   logic         reset;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [W-1:0] req0_srcA, req0_srcB, req1_srcA, req1_srcB;
   logic [2:0]   req0_ctrl, req1_ctrl;
   logic [W-1:0] alu_srcA, alu_srcB, alu_result;
   logic [2:0]   alu_ctrl;
   logic         alu_zero;
   logic [1:0]   rsp_valid, rsp_ready;
   logic [W-1:0] rsp_result;
   logic         rsp_zero;
   logic         busy;

   int n_chk  = 0;
   int n_fail = 0;

   alu_share_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_srcA(req0_srcA), .req0_srcB(req0_srcB), .req0_ctrl(req0_ctrl),
      .req1_srcA(req1_srcA), .req1_srcB(req1_srcB), .req1_ctrl(req1_ctrl),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: add, sub, and, or, slt; undefined codes return 0.
   function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
      case (c)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd5:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         default: return '0;
      endcase
   endfunction

   always_comb begin
      alu_result = alu_fn(alu_srcA, alu_srcB, alu_ctrl);
      alu_zero   = (alu_result == '0);
   end

   // Transaction-level model: age = cycles since acceptance (0 = idle, 1 = executing, 2 = responding).
   int           m_age;
   int           m_gid;
   bit           m_last;
   logic [W-1:0] m_a, m_b, m_res;
   logic [2:0]   m_c;
   logic         m_zero;

   function automatic int pick(input logic [1:0] v, input bit lastg);
      if (v == 2'b00) return -1;
      if (v == 2'b01) return 0;
      if (v == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return lastg ? 0 : 1;
`endif
   endfunction

   task automatic model_reset();
      m_age = 0; m_gid = 0; m_last = 1'b1;
      m_a = '0; m_b = '0; m_c = 3'b000; m_res = '0; m_zero = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: compare at the falling edge, advance the model, return just after the rising edge.
   task automatic cycle();
      int w;
      logic [1:0] e_ready;
      @(negedge clk);
      w = pick(req_valid, m_last);
      e_ready = (!reset && m_age == 0 && w >= 0) ? (2'b01 << w) : 2'b00;
      chk("req_ready",  64'(req_ready), 64'(e_ready));
      chk("alu_srcA",   64'(alu_srcA),  64'(m_a));
      chk("alu_srcB",   64'(alu_srcB),  64'(m_b));
      chk("alu_ctrl",   64'(alu_ctrl),  64'(m_c));
      chk("rsp_valid",  64'(rsp_valid), (m_age == 2) ? 64'(2'b01 << m_gid) : 64'(0));
      chk("rsp_result", 64'(rsp_result), 64'(m_res));
      chk("rsp_zero",   64'(rsp_zero),  64'(m_zero));
      chk("busy",       64'(busy),      64'(m_age != 0));
      if (reset) model_reset();
      else if (m_age == 0) begin
         if (w >= 0) begin
            m_gid = w; m_last = (w == 1); m_age = 1;
            m_a = (w == 1) ? req1_srcA : req0_srcA;
            m_b = (w == 1) ? req1_srcB : req0_srcB;
            m_c = (w == 1) ? req1_ctrl : req0_ctrl;
         end
      end else if (m_age == 1) begin
         m_res = alu_fn(m_a, m_b, m_c); m_zero = (m_res == '0); m_age = 2;
      end else if (rsp_ready[m_gid]) m_age = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drive(input logic [1:0] v,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] c0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] c1,
                        input logic [1:0] rr);
      req_valid = v;
      req0_srcA = a0; req0_srcB = b0; req0_ctrl = c0;
      req1_srcA = a1; req1_srcB = b1; req1_ctrl = c1;
      rsp_ready = rr;
   endtask

   initial begin
      reset = 1'b1;
      drive(2'b11, 32'd9, 32'd9, 3'd0, 32'd4, 32'd4, 3'd0, 2'b00);
      model_reset();
      @(posedge clk); #1;
      run(2);                                    // reset held: req_ready must stay low

      // Single add from requester 0; response two cycles after acceptance.
      reset = 1'b0;
      drive(2'b01, 32'd5, 32'd3, 3'd0, 32'd0, 32'd0, 3'd0, 2'b11);
      cycle();
      drive(2'b00, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 3'd0, 2'b11);
      cycle();
      chk("lat_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      chk("lat_rsp_result", 64'(rsp_result), 64'd8);
      chk("lat_rsp_zero", 64'(rsp_zero), 64'd0);
      run(2);

      // Backpressure: response held five cycles, wrong-bit ready ignored, then released.
      drive(2'b01, 32'd5, 32'd3, 3'd0, 32'd0, 32'd0, 3'd0, 2'b00);
      cycle();
      drive(2'b11, 32'd1, 32'd1, 3'd1, 32'd2, 32'd2, 3'd1, 2'b00);
      run(6);
      rsp_ready = 2'b10;
      run(2);
      chk("bp_result", 64'(rsp_result), 64'd8);
      chk("bp_busy", 64'(busy), 64'd1);
      req_valid = 2'b00;
      rsp_ready = 2'b01;
      cycle();
      chk("bp_release_busy", 64'(busy), 64'd0);

      // Withdrawn request in IDLE leaves nothing behind.
      drive(2'b00, 32'd11, 32'd12, 3'd2, 32'd13, 32'd14, 3'd3, 2'b11);
      run(2);

      // slt with negative operand, then undefined code.
      drive(2'b10, 32'd0, 32'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 3'd5, 2'b11);
      cycle();
      req_valid = 2'b00;
      cycle();
      chk("slt_result", 64'(rsp_result), 64'd1);
      cycle();
      drive(2'b10, 32'd0, 32'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 3'd7, 2'b11);
      cycle();
      req_valid = 2'b00;
      cycle();
      chk("undef_result", 64'(rsp_result), 64'd0);
      chk("undef_zero", 64'(rsp_zero), 64'd1);
      cycle();

      // Both requesting continuously with sub 7-7: alternating grants every three cycles.
      drive(2'b11, 32'd7, 32'd7, 3'd1, 32'd7, 32'd7, 3'd1, 2'b11);
      run(12);
      req_valid = 2'b00;
      run(3);

      // Reset during EXEC abandons the operation; next tie goes to requester 0.
      drive(2'b10, 32'd1, 32'd2, 3'd0, 32'd3, 32'd4, 3'd0, 2'b11);
      cycle();
      req_valid = 2'b00;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rst_exec_valid", 64'(rsp_valid), 64'd0);
      chk("rst_exec_busy", 64'(busy), 64'd0);
      req_valid = 2'b11;
      cycle();
      chk("rst_tie_alu_a", 64'(alu_srcA), 64'd1);
      req_valid = 2'b00;
      run(3);

      // Random traffic with occasional reset.
      for (int i = 0; i < 500; i++) begin
         req_valid = 2'($urandom_range(0, 3));
         req0_srcA = ($urandom_range(0, 3) == 0) ? req0_srcB : W'($urandom);
         req0_srcB = W'($urandom);
         req0_ctrl = 3'($urandom_range(0, 7));
         req1_srcA = W'($urandom);
         req1_srcB = ($urandom_range(0, 3) == 0) ? req1_srcA : W'($urandom);
         req1_ctrl = 3'($urandom_range(0, 7));
         rsp_ready = 2'($urandom_range(0, 3));
         reset     = ($urandom_range(0, 39) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  input  2  bit i = requester i presents an operation.
REQ-005 Port: req_ready  output  2  bit i = operation from requester i is accepted this cycle.
REQ-006 Port: req0_srcA, req0_srcB  input  WIDTH each  requester 0 operands.
REQ-007 Port: req0_ctrl  input  3  requester 0 ALU control code.
REQ-008 Port: req1_srcA, req1_srcB  input  WIDTH each  requester 1 operands.
REQ-009 Port: req1_ctrl  input  3  requester 1 ALU control code.
REQ-010 Port: alu_srcA, alu_srcB  output  WIDTH each  operands driven to the shared ALU.
REQ-011 Port: alu_ctrl  output  3  control code driven to the shared ALU.
REQ-012 Port: alu_result  input  WIDTH  combinational ALU result.
REQ-013 Port: alu_zero  input  1  combinational ALU zero flag.
REQ-014 Port: rsp_valid  output  2  one-hot; bit i = response pending for requester i.
REQ-015 Port: rsp_ready  input  2  bit i = requester i consumes response.
REQ-016 Port: rsp_result  output  WIDTH  captured ALU result.
REQ-017 Port: rsp_zero  output  1  captured ALU zero flag.
REQ-018 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, EXEC and RESP, one operation in flight at most.
REQ-020 req_ready[i] SHALL be high only in IDLE for the granted requester, combinationally from req_valid and the grant policy; at most one bit high.
REQ-021 Acceptance (req_valid[i] & req_ready[i]) SHALL latch srcA, srcB, ctrl and grant id, and move IDLE->EXEC.
REQ-022 In EXEC, alu_srcA/alu_srcB/alu_ctrl SHALL equal the latched values; alu_result/alu_zero SHALL be captured into rsp_result/rsp_zero at the end of EXEC, moving EXEC->RESP.
REQ-023 Outside EXEC, alu_* outputs SHALL hold the last latched values.
REQ-024 In RESP, rsp_valid SHALL be one-hot on the granted id and held, with rsp_result/rsp_zero stable, until the matching rsp_ready bit is high; then RESP->IDLE.
REQ-025 rsp_ready on the non-granted bit SHALL be ignored.
REQ-026 Latency: acceptance in cycle N SHALL produce rsp_valid in cycle N+2; with rsp_ready held high, minimum issue interval is 3 cycles.
REQ-027 Round-robin: with both valid, grant SHALL go to the requester not granted last; with one valid, that one is granted.
REQ-028 Requester withdrawing req_valid in IDLE before acceptance SHALL leave no state change.
REQ-029 ctrl codes SHALL pass through unfiltered; undefined codes (100, 110, 111) yield whatever the ALU returns (result 0, zero 1).
REQ-030 req_valid arriving during EXEC/RESP SHALL not be accepted until return to IDLE.

Reset
REQ-031 Reset SHALL force state IDLE, req_ready 0 during the reset cycle, rsp_valid 0, rsp_result 0, rsp_zero 0, alu_srcA/alu_srcB 0, alu_ctrl 000, busy 0, last-grant pointer = requester 1 (so requester 0 wins first tie).
REQ-032 Reset asserted in EXEC or RESP SHALL abandon the operation with no response delivered.

Configuration
REQ-033 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win ties (pointer unused); when undefined, round-robin per REQ-027.

Verification
REQ-034 Req0 only: srcA=5, srcB=3, ctrl=000 accepted cycle N -> rsp_valid=01 at N+2, rsp_result=8, rsp_zero=0.
REQ-035 Both valid continuously, ctrl=001, srcA=srcB=7, rsp_ready=11 -> grants alternate 0,1,0,1 (fixed 0,0,0 with ALU_ARB_FIXED_PRIO_EN); rsp_result=0, rsp_zero=1; issue every 3 cycles.
REQ-036 Response backpressure: rsp_ready=00 for 5 cycles in RESP -> rsp_valid and rsp_result=8 held stable, req_ready=00, busy=1; rsp_ready=01 -> IDLE next cycle.
REQ-037 slt: srcA=-1 (FFFFFFFF), srcB=1, ctrl=101 -> rsp_result=1; ctrl=111 -> rsp_result=0, rsp_zero=1.
REQ-038 Reset pulsed in EXEC -> next cycle state IDLE, rsp_valid=00, busy=0; subsequent tie grants requester 0.
